// File: rtl/rv32imc_types.sv
// rv32imc_types: shared types for the RV32IMC execute stage.
package rv32imc_types;

   typedef enum logic [1:0] {
      ss_div = 2'b00,
      uu_div = 2'b01,
      ss_rem = 2'b10,
      uu_rem = 2'b11
   } div_type_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } div_state_t;

   function automatic int div_iters(input int width, input int bits_per_cycle);
      return width / bits_per_cycle;
   endfunction

   localparam int DIV_WIDTH = 32;
   localparam int DIV_BITS_PER_CYCLE = 1;
   localparam int DIV_ITERS = div_iters(DIV_WIDTH, DIV_BITS_PER_CYCLE);

endpackage

// File: rtl/rv32_div_step.sv
// rv32_div_step: one combinational restoring division step (shift-in, trial subtract, select).
module rv32_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] quot_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out,
   output logic [WIDTH-1:0] quot_out
);

   logic [WIDTH+1:0] shifted, diff;
   logic qb;

   always_comb begin
      shifted  = {rem_in, quot_in[WIDTH-1]};
      diff     = shifted - {2'b00, divisor};
      qb       = ~diff[WIDTH+1];
      rem_out  = qb ? diff[WIDTH:0] : shifted[WIDTH:0];
      quot_out = {quot_in[WIDTH-2:0], qb};
   end

endmodule

// File: rtl/rv32_iter_divider.sv
// rv32_iter_divider: multi-cycle restoring divider/remainder unit with valid/ready handshake.
// Dividend magnitude sits in quot and shifts out MSB-first while quotient bits shift in.
module rv32_iter_divider
   import rv32imc_types::*;
#(
   parameter int WIDTH = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  div_type_t        div_type,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] result
);

   localparam int ITERS = div_iters(WIDTH, BITS_PER_CYCLE);
   localparam int CW = $clog2(ITERS + 1);
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_t state, state_nxt;
   div_type_t typ;
   logic [CW-1:0] count;
   logic [WIDTH:0] rem;
   logic [WIDTH-1:0] quot, dsr, a_mag, b_mag, special_res, q_fin, r_fin, calc_res;
   logic q_neg, r_neg, sgn, a_neg, b_neg, div_zero, ovf, special, last;
   logic [WIDTH:0] rem_c [BITS_PER_CYCLE+1];
   logic [WIDTH-1:0] quot_c [BITS_PER_CYCLE+1];

   assign rem_c[0] = rem;
   assign quot_c[0] = quot;

   for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
      rv32_div_step #(.WIDTH(WIDTH)) u_step (
         .rem_in  (rem_c[i]),
         .quot_in (quot_c[i]),
         .divisor (dsr),
         .rem_out (rem_c[i+1]),
         .quot_out(quot_c[i+1])
      );
   end

   always_comb begin
      sgn         = ~div_type[0];
      a_neg       = sgn & dividend[WIDTH-1];
      b_neg       = sgn & divisor[WIDTH-1];
      a_mag       = a_neg ? -dividend : dividend;
      b_mag       = b_neg ? -divisor : divisor;
      div_zero    = divisor == '0;
      ovf         = sgn && dividend == MIN && &divisor;
      special     = div_zero | ovf;
      special_res = div_type[1] ? (div_zero ? dividend : '0) : (div_zero ? '1 : MIN);
      q_fin       = quot_c[BITS_PER_CYCLE];
      r_fin       = rem_c[BITS_PER_CYCLE][WIDTH-1:0];
      calc_res    = typ[1] ? ((~typ[0] & r_neg) ? -r_fin : r_fin)
                           : ((~typ[0] & q_neg) ? -q_fin : q_fin);
      last        = count == CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;

   // flush overrides every transition, including acceptance in IDLE
   always_comb
      state_nxt = flush           ? IDLE :
                  state == IDLE   ? (req_valid ? (special ? DONE : CALC) : IDLE) :
                  state == CALC   ? (last ? DONE : CALC) :
                  resp_ready      ? IDLE : DONE;

   always_comb begin
      req_ready  = state == IDLE;
      resp_valid = state == DONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         typ    <= ss_div;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         count  <= '0;
         rem    <= '0;
         quot   <= '0;
         dsr    <= '0;
         result <= '0;
      end else if (!flush) begin
         if (state == IDLE && req_valid) begin
            typ   <= div_type;
            q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg <= dividend[WIDTH-1];
            count <= CW'(ITERS);
            rem   <= '0;
            quot  <= a_mag;
            dsr   <= b_mag;
            if (special) result <= special_res;
         end else if (state == CALC) begin
            rem   <= rem_c[BITS_PER_CYCLE];
            quot  <= quot_c[BITS_PER_CYCLE];
            count <= count - 1'b1;
            if (last) result <= calc_res;
         end
      end
   end

endmodule

// File: tb/tb_rv32_iter_divider.sv
// tb_rv32_iter_divider: directed vectors plus handshake, flush, reset and radix-16 sequences.
module tb_rv32_iter_divider;
   import rv32imc_types::*;

   logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
   logic req_valid = 1'b0, resp_ready = 1'b0, req_valid4 = 1'b0, resp_ready4 = 1'b0;
   div_type_t div_type = uu_div;
   logic [31:0] dividend = '0, divisor = '0;
   logic req_ready, resp_valid, req_ready4, resp_valid4;
   logic [31:0] result, result4;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   rv32_iter_divider #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
      .div_type(div_type), .dividend(dividend), .divisor(divisor),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .result(result)
   );

   rv32_iter_divider #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid4), .req_ready(req_ready4),
      .div_type(div_type), .dividend(dividend), .divisor(divisor),
      .resp_valid(resp_valid4), .resp_ready(resp_ready4), .result(result4)
   );

   // lat = clock edges after the accept edge until resp_valid is seen; special cases give 0
   typedef struct {
      div_type_t t;
      logic [31:0] a, b, exp;
      int lat;
   } vec_t;

   vec_t vecs[16];
   vec_t vecs4[3];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic issue(input div_type_t t, input logic [31:0] a, input logic [31:0] b, output int lat);
      @(negedge clk);
      div_type = t; dividend = a; divisor = b; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      while (!resp_valid && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic pop(input string nm);
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      chk({nm, "_valid_drop"}, 32'(resp_valid), 32'd0);
      chk({nm, "_ready_back"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      bit seen;
      vecs[0]  = '{uu_div, 32'd100,        32'd7,          32'd14,         32};
      vecs[1]  = '{uu_rem, 32'd100,        32'd7,          32'd2,          32};
      vecs[2]  = '{ss_div, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32};
      vecs[3]  = '{ss_rem, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32};
      vecs[4]  = '{ss_rem, 32'd7,          32'hFFFFFFFE,   32'd1,          32};
      vecs[5]  = '{ss_div, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32};
      vecs[6]  = '{uu_div, 32'd5,          32'd0,          32'hFFFFFFFF,   0};
      vecs[7]  = '{ss_rem, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   0};
      vecs[8]  = '{ss_div, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   0};
      vecs[9]  = '{ss_div, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   0};
      vecs[10] = '{ss_rem, 32'h80000000,   32'hFFFFFFFF,   32'd0,          0};
      vecs[11] = '{uu_div, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32};
      vecs[12] = '{uu_rem, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32};
      vecs[13] = '{ss_div, 32'h80000000,   32'd2,          32'hC0000000,   32};
      vecs[14] = '{uu_div, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32};
      vecs[15] = '{uu_rem, 32'd0,          32'd5,          32'd0,          32};
      vecs4[0] = '{uu_div, 32'hFFFFFFFF,   32'd3,          32'h55555555,   8};
      vecs4[1] = '{uu_rem, 32'd100,        32'd7,          32'd2,          8};
      vecs4[2] = '{ss_div, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   8};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         issue(vecs[i].t, vecs[i].a, vecs[i].b, lat);
         chk($sformatf("vec%0d_result", i), result, vecs[i].exp);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         pop($sformatf("vec%0d", i));
      end

      // back-pressure: result held, and no new request taken while DONE
      issue(uu_div, 32'd1000, 32'd10, lat);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         dividend = 32'd9; divisor = 32'd3; req_valid = 1'b1;
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d_result", i), result, 32'd100);
         chk($sformatf("bp%0d_valid", i), 32'(resp_valid), 32'd1);
         chk($sformatf("bp%0d_req_ready", i), 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      pop("bp");

      // flush on the fifth CALC cycle, with a competing request in the same cycle
      @(negedge clk);
      div_type = uu_div; dividend = 32'd50; divisor = 32'd3; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      flush = 1'b1; req_valid = 1'b1; dividend = 32'd77;
      @(posedge clk);
      #1 flush = 1'b0; req_valid = 1'b0;
      chk("flush_req_ready", 32'(req_ready), 32'd1);
      chk("flush_resp_valid", 32'(resp_valid), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1 if (resp_valid || !req_ready) seen = 1'b1;
      end
      chk("flush_no_resp", 32'(seen), 32'd0);
      issue(uu_div, 32'd100, 32'd7, lat);
      chk("post_flush_result", result, 32'd14);
      chk("post_flush_latency", 32'(lat), 32'd32);
      pop("post_flush");

      // asynchronous reset in the middle of CALC
      @(negedge clk);
      div_type = uu_div; dividend = 32'd60; divisor = 32'd4; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_req_ready", 32'(req_ready), 32'd1);
      chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
      chk("midrst_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1 if (resp_valid) seen = 1'b1;
      end
      chk("midrst_no_resp", 32'(seen), 32'd0);

      // radix-16 instance
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         div_type = vecs4[i].t; dividend = vecs4[i].a; divisor = vecs4[i].b; req_valid4 = 1'b1;
         @(posedge clk);
         #1 req_valid4 = 1'b0;
         lat = 0;
         while (!resp_valid4 && lat < 100) begin
            @(posedge clk);
            #1 lat++;
         end
         chk($sformatf("r4_vec%0d_result", i), result4, vecs4[i].exp);
         chk($sformatf("r4_vec%0d_latency", i), 32'(lat), 32'(vecs4[i].lat));
         @(negedge clk);
         resp_ready4 = 1'b1;
         @(posedge clk);
         #1 resp_ready4 = 1'b0;
         chk($sformatf("r4_vec%0d_valid_drop", i), 32'(resp_valid4), 32'd0);
         chk($sformatf("r4_vec%0d_ready_back", i), 32'(req_ready4), 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
